// File: rtl/async_op_arbiter.sv
// Round-robin scheduler sharing one pipelined operator (addi/subi/muli/reg) across num_ch
// req/ack channels. Define ASYNC_OP_ARB_STATS_EN to add per-channel served_count counters.
module async_op_arbiter #(
    parameter int unsigned num_ch     = 4,
    parameter int unsigned data_width = 32,
    parameter string       op         = "addi",
    parameter int unsigned immediate  = 2,
    parameter int unsigned op_latency = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_ch-1:0]            ch_en,
    output logic [num_ch-1:0]            src_req,
    input  logic [num_ch-1:0]            src_ack,
    input  logic [data_width*num_ch-1:0] src_din,
    input  logic [num_ch-1:0]            snk_req,
    output logic [num_ch-1:0]            snk_ack,
    output logic [data_width-1:0]        dout,
    output logic [num_ch-1:0]            grant,
    output logic                         busy
`ifdef ASYNC_OP_ARB_STATS_EN
    ,
    output logic [32*num_ch-1:0]         served_count
`endif
);

    localparam int unsigned pw = (num_ch > 1) ? $clog2(num_ch) : 1;
    localparam logic [data_width-1:0] imm_w = data_width'(immediate);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StDeliver} state_e;

    state_e                state_q, state_d;
    logic [pw-1:0]         ptr_q, ptr_d;
    logic [pw-1:0]         sel_q, sel_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [data_width-1:0] operand_q, operand_d;
    logic [data_width-1:0] result_q, result_d;
    logic [num_ch-1:0]     src_req_q, src_req_d;
    logic [num_ch-1:0]     snk_ack_q, snk_ack_d;
    logic [data_width-1:0] dout_q, dout_d;

    logic [data_width-1:0] din_arr [num_ch];
    logic [data_width-1:0] op_result;
    logic [pw-1:0]         first_sel;
    logic [pw-1:0]         idx;
    logic                  found;

    function automatic logic [num_ch-1:0] onehot(input logic [pw-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    for (genvar i = 0; i < num_ch; i++) begin : g_din
        assign din_arr[i] = src_din[data_width*i +: data_width];
    end

    if (op == "addi") begin : g_addi
        assign op_result = operand_q + imm_w;
    end else if (op == "subi") begin : g_subi
        assign op_result = operand_q - imm_w;
    end else if (op == "muli") begin : g_muli
        assign op_result = operand_q * imm_w;
    end else begin : g_reg
        assign op_result = operand_q;
    end

    // First enabled channel at or after ptr, searched cyclically.
    always_comb begin
        first_sel = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < num_ch; k++) begin
            idx = pw'((32'(ptr_q) + k) % num_ch);
            if (!found && ch_en[idx]) begin
                found     = 1'b1;
                first_sel = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        result_d  = result_q;
        src_req_d = src_req_q;
        snk_ack_d = '0;
        dout_d    = dout_q;
        unique case (state_q)
            StIdle: begin
                if (|ch_en) begin
                    sel_d     = first_sel;
                    src_req_d = onehot(first_sel);
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                if (src_ack[sel_q]) begin
                    operand_d = din_arr[sel_q];
                    src_req_d = '0;
                    cnt_d     = 4'(op_latency);
                    state_d   = StExec;
                end
            end
            StExec: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = op_result;
                    state_d  = StDeliver;
                end
            end
            StDeliver: begin
                if (snk_req[sel_q]) begin
                    dout_d    = result_q;
                    snk_ack_d = onehot(sel_q);
                    ptr_d     = (sel_q == pw'(num_ch - 1)) ? '0 : sel_q + 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            operand_q <= '0;
            result_q  <= '0;
            src_req_q <= '0;
            snk_ack_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            src_req_q <= src_req_d;
            snk_ack_q <= snk_ack_d;
            dout_q    <= dout_d;
        end
    end

    assign src_req = src_req_q;
    assign snk_ack = snk_ack_q;
    assign dout    = dout_q;
    assign busy    = (state_q != StIdle);
    assign grant   = busy ? onehot(sel_q) : '0;

`ifdef ASYNC_OP_ARB_STATS_EN
    for (genvar i = 0; i < num_ch; i++) begin : g_stats
        logic [31:0] served_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                served_q <= '0;
            end else if (snk_ack_q[i]) begin
                served_q <= served_q + 32'd1;
            end
        end
        assign served_count[32*i +: 32] = served_q;
    end
`endif

endmodule
